// File: rtl/fb_scanout.sv
// Framebuffer scan-out engine. It generates LCD timing, reads palette indices from a video RAM
// with integer scaling, looks each index up in an RGB565 palette, and can swap buffers at frame end.
module fb_scanout #(
  parameter int unsigned H_ACTIVE   = 480,
  parameter int unsigned H_FP       = 2,
  parameter int unsigned H_SYNC     = 41,
  parameter int unsigned H_BP       = 2,
  parameter int unsigned V_ACTIVE   = 272,
  parameter int unsigned V_FP       = 2,
  parameter int unsigned V_SYNC     = 10,
  parameter int unsigned V_BP       = 2,
  parameter int unsigned FB_W       = 256,
  parameter int unsigned FB_H       = 256,
  parameter int unsigned SCALE_X    = 2,
  parameter int unsigned SCALE_Y    = 1,
  parameter int unsigned BPP        = 1,
  parameter int unsigned DOUBLE_BUF = 0,
  parameter int unsigned SYNC_POL   = 0
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_wr_valid,
  output logic                            o_wr_ready,
  input  logic [$clog2(FB_W*FB_H)-1:0]    i_wr_addr,
  input  logic [BPP-1:0]                  i_wr_data,
  input  logic                            i_pal_we,
  input  logic [BPP-1:0]                  i_pal_idx,
  input  logic [15:0]                     i_pal_data,
  input  logic                            i_swap_req,
  output logic                            o_swap_ack,
  output logic [4:0]                      o_r,
  output logic [5:0]                      o_g,
  output logic [4:0]                      o_b,
  output logic                            o_hsync,
  output logic                            o_vsync,
  output logic                            o_den
);

  localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW        = $clog2(H_TOTAL);
  localparam int unsigned VW        = $clog2(V_TOTAL);
  localparam int unsigned XW        = $clog2(FB_W);
  localparam int unsigned YW        = $clog2(FB_H);
  localparam int unsigned AW        = XW + YW;
  localparam int unsigned FXW       = (XW > HW) ? XW : HW;
  localparam int unsigned FYW       = (YW > VW) ? YW : VW;
  localparam int unsigned MAW       = AW + ((DOUBLE_BUF != 0) ? 1 : 0);
  localparam int unsigned MEM_DEPTH = 2 ** MAW;
  localparam int unsigned PAL_N     = 2 ** BPP;
  localparam int unsigned SXW       = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;
  localparam int unsigned SYW       = (SCALE_Y > 1) ? $clog2(SCALE_Y) : 1;
  localparam bit          DB        = (DOUBLE_BUF != 0);

  logic [HW-1:0]  hcnt_q, hcnt_d;
  logic [VW-1:0]  vcnt_q, vcnt_d;
  logic [SXW-1:0] sx_q, sx_d;
  logic [SYW-1:0] sy_q, sy_d;
  logic [FXW-1:0] fx_q, fx_d;
  logic [FYW-1:0] fy_q, fy_d;
  logic           front_q, front_d;
  logic           pend_q, pend_d;
  logic           vis_q, vis_d;
  logic [1:0]     hs_sr_q, hs_sr_d;
  logic [1:0]     vs_sr_q, vs_sr_d;
  logic [1:0]     de_sr_q, de_sr_d;
  logic [15:0]    rgb_q, rgb_d;
  logic [15:0]    pal_q [PAL_N];
  logic [15:0]    pal_d [PAL_N];

  logic [BPP-1:0] mem_q [MEM_DEPTH];
  logic [BPP-1:0] rd_data_q;

  logic           h_wrap, v_last, swap_cycle, swap_ack;
  logic           de, hs_act, vs_act, in_range, wr_fire;
  logic [MAW-1:0] rd_addr, wr_addr;
  logic [BPP-1:0] idx;

  // Raster counters plus scale sub-counters that step the framebuffer coordinates.
  always_comb begin
    h_wrap = (hcnt_q == HW'(H_TOTAL - 1));
    v_last = (vcnt_q == VW'(V_TOTAL - 1));
    hcnt_d = h_wrap ? '0 : hcnt_q + HW'(1);
    vcnt_d = vcnt_q;
    sx_d   = sx_q + SXW'(1);
    fx_d   = fx_q;
    sy_d   = sy_q;
    fy_d   = fy_q;
    if (h_wrap) begin
      vcnt_d = v_last ? '0 : vcnt_q + VW'(1);
      sx_d   = '0;
      fx_d   = '0;
      if (v_last) begin
        sy_d = '0;
        fy_d = '0;
      end else if (sy_q == SYW'(SCALE_Y - 1)) begin
        sy_d = '0;
        fy_d = fy_q + FYW'(1);
      end else begin
        sy_d = sy_q + SYW'(1);
      end
    end else if (sx_q == SXW'(SCALE_X - 1)) begin
      sx_d = '0;
      fx_d = fx_q + FXW'(1);
    end
  end

  always_comb begin
    de       = (32'(hcnt_q) < H_ACTIVE) && (32'(vcnt_q) < V_ACTIVE);
    hs_act   = (32'(hcnt_q) >= H_ACTIVE + H_FP) && (32'(hcnt_q) < H_ACTIVE + H_FP + H_SYNC);
    vs_act   = (32'(vcnt_q) >= V_ACTIVE + V_FP) && (32'(vcnt_q) < V_ACTIVE + V_FP + V_SYNC);
    in_range = (32'(fx_q) < FB_W) && (32'(fy_q) < FB_H);
    // Single-buffered builds drop the buffer-select bit through the width cast.
    rd_addr  = MAW'({front_q, fy_q[YW-1:0], fx_q[XW-1:0]});
    wr_addr  = MAW'({~front_q, i_wr_addr});
    vis_d    = de & in_range;
    hs_sr_d  = {hs_sr_q[0], hs_act};
    vs_sr_d  = {vs_sr_q[0], vs_act};
    de_sr_d  = {de_sr_q[0], de};
  end

  // Swap bookkeeping: a request seen in the swap cycle itself waits for the next frame.
  always_comb begin
    swap_cycle = h_wrap && (vcnt_q == VW'(V_ACTIVE - 1));
    swap_ack   = swap_cycle & pend_q;
    front_d    = front_q ^ swap_ack;
    pend_d     = (pend_q & ~swap_cycle) | (i_swap_req & DB);
    wr_fire    = i_wr_valid & ~swap_cycle;
  end

  always_comb begin
    idx   = vis_q ? rd_data_q : '0;
    rgb_d = de_sr_q[0] ? pal_q[idx] : 16'h0000;
    for (int i = 0; i < PAL_N; i++) begin
      pal_d[i] = pal_q[i];
    end
    if (i_pal_we) begin
      pal_d[i_pal_idx] = i_pal_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      fx_q    <= '0;
      fy_q    <= '0;
      front_q <= 1'b0;
      pend_q  <= 1'b0;
      vis_q   <= 1'b0;
      hs_sr_q <= '0;
      vs_sr_q <= '0;
      de_sr_q <= '0;
      rgb_q   <= '0;
      for (int i = 0; i < PAL_N; i++) begin
        pal_q[i] <= (i == 0) ? 16'h0000 : 16'hFFFF;
      end
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
      front_q <= front_d;
      pend_q  <= pend_d;
      vis_q   <= vis_d;
      hs_sr_q <= hs_sr_d;
      vs_sr_q <= vs_sr_d;
      de_sr_q <= de_sr_d;
      rgb_q   <= rgb_d;
      for (int i = 0; i < PAL_N; i++) begin
        pal_q[i] <= pal_d[i];
      end
    end
  end

  // Video RAM is not reset; a same-address read returns the pre-write data.
  always_ff @(posedge i_clk) begin
    if (wr_fire) begin
      mem_q[wr_addr] <= i_wr_data;
    end
    rd_data_q <= mem_q[rd_addr];
  end

  always_comb begin
    o_wr_ready = ~swap_cycle;
    o_swap_ack = swap_ack;
    o_r        = rgb_q[15:11];
    o_g        = rgb_q[10:5];
    o_b        = rgb_q[4:0];
    o_hsync    = (SYNC_POL != 0) ? hs_sr_q[1] : ~hs_sr_q[1];
    o_vsync    = (SYNC_POL != 0) ? vs_sr_q[1] : ~vs_sr_q[1];
    o_den      = de_sr_q[1];
  end

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout on a shrunken raster (23 clk x 10 lines, 4x4 framebuffer),
// with one single-buffered and one double-buffered instance sharing all inputs.
module tb_fb_scanout;

  localparam int FR = 230;
  localparam int LN = 23;

  logic        clk, rst_n, wr_valid, pal_we, swap_req;
  logic [3:0]  wr_addr;
  logic [1:0]  wr_data, pal_idx;
  logic [15:0] pal_data;

  logic        sb_ready, sb_ack, sb_hs, sb_vs, sb_den;
  logic        db_ready, db_ack, db_hs, db_vs, db_den;
  logic [4:0]  sb_r, sb_b, db_r, db_b;
  logic [5:0]  sb_g, db_g;
  logic [15:0] sb_rgb, db_rgb;

  assign sb_rgb = {sb_r, sb_g, sb_b};
  assign db_rgb = {db_r, db_g, db_b};

  int checks = 0;
  int failures = 0;
  int cyc;

  fb_scanout #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .FB_W(4), .FB_H(4), .SCALE_X(2), .SCALE_Y(1), .BPP(2), .DOUBLE_BUF(0), .SYNC_POL(0)
  ) u_sb (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_valid(wr_valid), .o_wr_ready(sb_ready),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_pal_we(pal_we), .i_pal_idx(pal_idx),
    .i_pal_data(pal_data), .i_swap_req(swap_req), .o_swap_ack(sb_ack), .o_r(sb_r), .o_g(sb_g),
    .o_b(sb_b), .o_hsync(sb_hs), .o_vsync(sb_vs), .o_den(sb_den)
  );

  fb_scanout #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2), .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .FB_W(4), .FB_H(4), .SCALE_X(2), .SCALE_Y(1), .BPP(2), .DOUBLE_BUF(1), .SYNC_POL(0)
  ) u_db (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_valid(wr_valid), .o_wr_ready(db_ready),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_pal_we(pal_we), .i_pal_idx(pal_idx),
    .i_pal_data(pal_data), .i_swap_req(swap_req), .o_swap_ack(db_ack), .o_r(db_r), .o_g(db_g),
    .o_b(db_b), .o_hsync(db_hs), .o_vsync(db_vs), .o_den(db_den)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index since reset release; cycle c carries raster position c.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int oc(input int f, input int v, input int h);
    return f * FR + v * LN + h + 2;
  endfunction

  task automatic do_write(input logic [3:0] a, input logic [1:0] d);
    logic acc;
    int   n;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    acc      = 1'b0;
    n        = 0;
    while (!acc && n < 8) begin
      acc = sb_ready;
      @(posedge clk);
      #1;
      n++;
    end
    wr_valid = 1'b0;
  endtask

  task automatic fill(input logic [1:0] d);
    for (int a = 0; a < 16; a++) do_write(4'(a), d);
  endtask

  task automatic test_reset;
    checks++; if (sb_hs !== 1'b1) begin failures++; $display("FAIL reset_hsync got %b want 1", sb_hs); end
    checks++; if (sb_vs !== 1'b1) begin failures++; $display("FAIL reset_vsync got %b want 1", sb_vs); end
    checks++; if (sb_den !== 1'b0) begin failures++; $display("FAIL reset_den got %b want 0", sb_den); end
    checks++; if (sb_rgb !== 16'h0) begin failures++; $display("FAIL reset_rgb got %h want 0000", sb_rgb); end
    checks++; if (db_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b want 1", db_ready); end
    checks++; if (db_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got %b want 0", db_ack); end
  endtask

  task automatic test_timing;
    int bad_hs, bad_vs, bad_de, bad_rgb, n_hs, n_vs, n_de, p, h, v;
    logic ehs, evs, ede;
    bad_hs = 0; bad_vs = 0; bad_de = 0; bad_rgb = 0; n_hs = 0; n_vs = 0; n_de = 0;
    for (int c = oc(1, 0, 0); c < oc(3, 0, 0); c++) begin
      wait_cyc(c);
      p   = c - 2;
      h   = p % LN;
      v   = (p / LN) % 10;
      ehs = !(h >= 18 && h < 21);
      evs = !(v >= 7 && v < 9);
      ede = (h < 16) && (v < 6);
      if (sb_hs !== ehs) bad_hs++;
      if (sb_vs !== evs) bad_vs++;
      if (sb_den !== ede) bad_de++;
      if (sb_rgb !== 16'h0) bad_rgb++;
      if (sb_hs === 1'b0) n_hs++;
      if (sb_vs === 1'b0) n_vs++;
      if (sb_den === 1'b1) n_de++;
    end
    checks++; if (bad_hs != 0) begin failures++; $display("FAIL t1_hsync_shape bad_cycles %0d want 0", bad_hs); end
    checks++; if (bad_vs != 0) begin failures++; $display("FAIL t1_vsync_shape bad_cycles %0d want 0", bad_vs); end
    checks++; if (bad_de != 0) begin failures++; $display("FAIL t1_den_shape bad_cycles %0d want 0", bad_de); end
    checks++; if (bad_rgb != 0) begin failures++; $display("FAIL t1_rgb_zero bad_cycles %0d want 0", bad_rgb); end
    checks++; if (n_hs != 60) begin failures++; $display("FAIL t1_hsync_low_count got %0d want 60", n_hs); end
    checks++; if (n_vs != 92) begin failures++; $display("FAIL t1_vsync_low_count got %0d want 92", n_vs); end
    checks++; if (n_de != 192) begin failures++; $display("FAIL t1_den_count got %0d want 192", n_de); end
  endtask

  task automatic test_pixels;
    do_write(4'd0, 2'd1);
    wait_cyc(oc(4, 0, 0));
    checks++; if (sb_den !== 1'b1) begin failures++; $display("FAIL t2_den_px0 got %b want 1", sb_den); end
    checks++; if (sb_rgb !== 16'hFFFF) begin failures++; $display("FAIL t2_px0 got %h want ffff", sb_rgb); end
    wait_cyc(oc(4, 0, 1));
    checks++; if (sb_rgb !== 16'hFFFF) begin failures++; $display("FAIL t2_px1 got %h want ffff", sb_rgb); end
    wait_cyc(oc(4, 0, 2));
    checks++; if (sb_rgb !== 16'h0) begin failures++; $display("FAIL t2_px2 got %h want 0000", sb_rgb); end
    wait_cyc(oc(4, 0, 8));
    checks++; if (sb_rgb !== 16'h0) begin failures++; $display("FAIL t2_x_out_of_range got %h want 0000", sb_rgb); end
    wait_cyc(oc(4, 0, 15));
    checks++; if (sb_den !== 1'b1) begin failures++; $display("FAIL t2_den_last got %b want 1", sb_den); end
    wait_cyc(oc(4, 0, 16));
    checks++; if (sb_den !== 1'b0) begin failures++; $display("FAIL t2_den_end got %b want 0", sb_den); end
    wait_cyc(oc(4, 4, 0));
    checks++; if (sb_rgb !== 16'h0) begin failures++; $display("FAIL t2_y_out_of_range got %h want 0000", sb_rgb); end
    do_write(4'd1, 2'd1);
  endtask

  task automatic test_palette;
    wait_cyc(5 * FR + 2);
    pal_idx  = 2'd1;
    pal_data = 16'hF800;
    pal_we   = 1'b1;
    @(posedge clk);
    #1;
    pal_we = 1'b0;
    wait_cyc(oc(5, 0, 1));
    checks++; if (sb_rgb !== 16'hFFFF) begin failures++; $display("FAIL t3_before got %h want ffff", sb_rgb); end
    wait_cyc(oc(5, 0, 2));
    checks++; if (sb_r !== 5'd31) begin failures++; $display("FAIL t3_red got %0d want 31", sb_r); end
    checks++; if (sb_g !== 6'd0) begin failures++; $display("FAIL t3_green got %0d want 0", sb_g); end
    checks++; if (sb_b !== 5'd0) begin failures++; $display("FAIL t3_blue got %0d want 0", sb_b); end
    wait_cyc(oc(5, 0, 3));
    checks++; if (sb_rgb !== 16'hF800) begin failures++; $display("FAIL t3_after got %h want f800", sb_rgb); end
  endtask

  task automatic test_swap;
    wait_cyc(6 * FR);
    fill(2'd2);
    wait_cyc(6 * FR + 2 * LN);
    swap_req = 1'b1;
    @(posedge clk);
    #1;
    swap_req = 1'b0;
    wait_cyc(6 * FR + 136);
    checks++; if (db_ack !== 1'b0) begin failures++; $display("FAIL t4_ack_early got %b want 0", db_ack); end
    checks++; if (db_ready !== 1'b1) begin failures++; $display("FAIL t4_ready_early got %b want 1", db_ready); end
    wait_cyc(6 * FR + 137);
    checks++; if (db_ack !== 1'b1) begin failures++; $display("FAIL t4_ack got %b want 1", db_ack); end
    checks++; if (db_ready !== 1'b0) begin failures++; $display("FAIL t4_ready_swap got %b want 0", db_ready); end
    checks++; if (sb_ack !== 1'b0) begin failures++; $display("FAIL t4_single_ack got %b want 0", sb_ack); end
    wait_cyc(6 * FR + 138);
    checks++; if (db_ack !== 1'b0) begin failures++; $display("FAIL t4_ack_late got %b want 0", db_ack); end
    checks++; if (db_ready !== 1'b1) begin failures++; $display("FAIL t4_ready_late got %b want 1", db_ready); end
    wait_cyc(oc(7, 0, 0));
    checks++; if (db_rgb !== 16'hFFFF) begin failures++; $display("FAIL t4_white_first got %h want ffff", db_rgb); end
    wait_cyc(oc(7, 3, 7));
    checks++; if (db_rgb !== 16'hFFFF) begin failures++; $display("FAIL t4_white_last got %h want ffff", db_rgb); end
    wait_cyc(oc(7, 3, 8));
    checks++; if (db_rgb !== 16'h0) begin failures++; $display("FAIL t4_beyond got %h want 0000", db_rgb); end
  endtask

  task automatic test_swap_defer;
    wait_cyc(7 * FR + 137);
    swap_req = 1'b1;
    checks++; if (db_ack !== 1'b0) begin failures++; $display("FAIL t5_no_ack_now got %b want 0", db_ack); end
    @(posedge clk);
    #1;
    swap_req = 1'b0;
    wait_cyc(8 * FR + 136);
    checks++; if (db_ack !== 1'b0) begin failures++; $display("FAIL t5_pre_ack got %b want 0", db_ack); end
    wait_cyc(8 * FR + 137);
    checks++; if (db_ack !== 1'b1) begin failures++; $display("FAIL t5_ack_next got %b want 1", db_ack); end
  endtask

  task automatic test_async_reset;
    do_write(4'd0, 2'd1);
    wait_cyc(oc(9, 0, 3));
    checks++; if (sb_rgb !== 16'hFFFF) begin failures++; $display("FAIL t6_pre got %h want ffff", sb_rgb); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (sb_den !== 1'b0) begin failures++; $display("FAIL t6_den got %b want 0", sb_den); end
    checks++; if (sb_rgb !== 16'h0) begin failures++; $display("FAIL t6_rgb got %h want 0000", sb_rgb); end
    checks++; if (sb_hs !== 1'b1) begin failures++; $display("FAIL t6_hsync got %b want 1", sb_hs); end
    checks++; if (db_vs !== 1'b1) begin failures++; $display("FAIL t6_vsync got %b want 1", db_vs); end
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    wait_cyc(2);
    checks++; if (sb_den !== 1'b1) begin failures++; $display("FAIL t6_den_restart got %b want 1", sb_den); end
    checks++; if (sb_rgb !== 16'hFFFF) begin failures++; $display("FAIL t6_palette_reset got %h want ffff", sb_rgb); end
    wait_cyc(19);
    checks++; if (sb_hs !== 1'b1) begin failures++; $display("FAIL t6_hsync_pre got %b want 1", sb_hs); end
    wait_cyc(20);
    checks++; if (sb_hs !== 1'b0) begin failures++; $display("FAIL t6_hsync_start got %b want 0", sb_hs); end
  endtask

  initial begin
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    pal_we   = 1'b0;
    pal_idx  = '0;
    pal_data = '0;
    swap_req = 1'b0;
    #12;
    test_reset;
    #10 rst_n = 1'b1;
    fill(2'd0);
    test_timing;
    test_pixels;
    test_palette;
    test_swap;
    test_swap_defer;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
